// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - shared encodings and request checks for the load unit
package load_pkg;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } funct_e;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      CAPT,
      DONE
   } state_e;

   // True when funct is a known load type and the offset suits its access size.
   function automatic logic req_ok(input logic [2:0] funct, input logic [1:0] offset);
      case (funct_e'(funct))
         LB, LBU: return 1'b1;
         LH, LHU: return ~offset[0];
         LW:      return offset == 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - lane select and sign/zero extension of a little-endian word
// Purely combinational so a cache read path can share it.
module load_extract
   import load_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct,
   output logic [31:0] value
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = word[{offset, 3'b000} +: 8];
      half_lane = word[{offset[1], 4'b0000} +: 16];
      case (funct_e'(funct))
         LB:      value = {{24{byte_lane[7]}}, byte_lane};
         LH:      value = {{16{half_lane[15]}}, half_lane};
         LW:      value = word;
         LBU:     value = {24'h0, byte_lane};
         LHU:     value = {16'h0, half_lane};
         default: value = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_box.sv
// rtl/load_box.sv - multicycle load unit: one aligned word read, fixed latency, extend
// Illegal or misaligned requests skip memory and complete next cycle with err set.
module load_box
   import load_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] addr,
   input  logic [2:0]  funct,
   input  logic [31:0] mem_rdata,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       offset_q;
   logic [2:0]       funct_q;
   logic [31:0]      ext_value;

   load_extract u_extract (
      .word   (mem_rdata),
      .offset (offset_q),
      .funct  (funct_q),
      .value  (ext_value)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         offset_q <= '0;
         funct_q  <= '0;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rdata    <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  offset_q <= addr[1:0];
                  funct_q  <= funct;
                  mem_addr <= {addr[31:2], 2'b00};
                  busy     <= 1'b1;
                  cnt      <= '0;
                  rdata    <= '0;
                  if (req_ok(funct, addr[1:0])) begin
                     state  <= REQ;
                     mem_rd <= 1'b1;
                     err    <= 1'b0;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end
               end
            end
            REQ: begin
               mem_rd <= 1'b0;
               cnt    <= cnt + 1'b1;
               // REQ itself is the first latency cycle, so a one-cycle memory needs no WAIT.
               state  <= (MEM_LAT == 1) ? CAPT : WAIT;
            end
            WAIT: begin
               if (cnt == CNT_W'(MEM_LAT - 1)) begin
                  state <= CAPT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CAPT: begin
               rdata <= ext_value;
               err   <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_box.sv
// tb/tb_load_box.sv - scoreboard bench for load_box at memory latencies 1, 2 and 3
module tb_load_box;

   localparam int LATS [3] = '{1, 2, 3};
   localparam logic [2:0] FUNCTS [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] addr;
   logic [2:0]  funct;
   logic [31:0] mem_word;
   logic [2:0]  start_v;
   logic [2:0]  mem_rd_v;
   logic [2:0]  busy_v;
   logic [2:0]  done_v;
   logic [2:0]  err_v;
   logic [31:0] mem_addr_v  [3];
   logic [31:0] mem_rdata_v [3];
   logic [31:0] rdata_v     [3];
   logic [15:0] rd_pipe     [3];
   int          rd_cnt      [3];
   exp_t        exp_q       [3][$];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      load_box #(.MEM_LAT(LATS[g])) u_dut (
         .clk       (clk),
         .reset_n   (reset_n),
         .start     (start_v[g]),
         .addr      (addr),
         .funct     (funct),
         .mem_rdata (mem_rdata_v[g]),
         .mem_rd    (mem_rd_v[g]),
         .mem_addr  (mem_addr_v[g]),
         .busy      (busy_v[g]),
         .done      (done_v[g]),
         .rdata     (rdata_v[g]),
         .err       (err_v[g])
      );
   end

   // Memory returns the word exactly MEM_LAT cycles after mem_rd, inverted garbage otherwise.
   always @(posedge clk or negedge reset_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!reset_n) begin
            rd_pipe[i] <= '0;
         end else begin
            rd_pipe[i] <= {rd_pipe[i][14:0], mem_rd_v[i]};
            if (mem_rd_v[i]) rd_cnt[i] <= rd_cnt[i] + 1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         mem_rdata_v[i] = rd_pipe[i][LATS[i]-1] ? mem_word : ~mem_word;
      end
   end

   function automatic exp_t model_load(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f);
      exp_t        e;
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * off)) & 32'h0000_00FF;
      h = (w >> (16 * off[1])) & 32'h0000_FFFF;
      e.err   = 1'b0;
      e.rdata = 32'h0;
      case (f)
         3'b000:  e.rdata = b[7] ? (b | 32'hFFFF_FF00) : b;
         3'b001:  if (off[0]) e.err = 1'b1; else e.rdata = h[15] ? (h | 32'hFFFF_0000) : h;
         3'b010:  if (off != 2'b00) e.err = 1'b1; else e.rdata = w;
         3'b100:  e.rdata = b;
         3'b101:  if (off[0]) e.err = 1'b1; else e.rdata = h;
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   // Pulses start for one cycle and returns at the falling edge of cycle 1.
   task automatic start_req(input int g, input logic [31:0] a, input logic [2:0] f, input logic [31:0] w);
      @(posedge clk);
      #1;
      addr     = a;
      funct    = f;
      mem_word = w;
      exp_q[g].push_back(model_load(w, a[1:0], f));
      start_v[g] = 1'b1;
      @(posedge clk);
      #1;
      start_v[g] = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_done(input int g, output int cyc);
      cyc = 1;
      while (!done_v[g] && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      reset_n  = 1'b1;
      start_v  = '0;
      addr     = '0;
      funct    = '0;
      mem_word = '0;
      #3 reset_n = 1'b0;
      #10;
      for (int g = 0; g < 3; g++) begin
         n_checks++;
         if ({mem_rd_v[g], busy_v[g], done_v[g], err_v[g]} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl[%0d]: mem_rd/busy/done/err got %b expected 0000", g,
                     {mem_rd_v[g], busy_v[g], done_v[g], err_v[g]});
         end
         n_checks++;
         if (mem_addr_v[g] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mem_addr[%0d]: got %h expected 00000000", g, mem_addr_v[g]);
         end
         n_checks++;
         if (rdata_v[g] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata[%0d]: got %h expected 00000000", g, rdata_v[g]);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lb_lat1();
      int   cyc;
      exp_t e;
      start_req(0, 32'h0000_0103, 3'b000, 32'h80FF_1234);
      n_checks++;
      if (mem_rd_v[0] !== 1'b1 || mem_addr_v[0] !== 32'h0000_0100) begin
         n_fail++;
         $display("FAIL lb_req: mem_rd=%b mem_addr=%h expected 1 00000100", mem_rd_v[0], mem_addr_v[0]);
      end
      wait_done(0, cyc);
      n_checks++;
      if (cyc != 3) begin
         n_fail++;
         $display("FAIL lb_latency: done in cycle %0d expected 3", cyc);
      end
      e = exp_q[0].pop_front();
      n_checks++;
      if (rdata_v[0] !== e.rdata || err_v[0] !== e.err) begin
         n_fail++;
         $display("FAIL lb_data: rdata=%h err=%b expected %h %b", rdata_v[0], err_v[0], e.rdata, e.err);
      end
      @(negedge clk);
      n_checks++;
      if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || rdata_v[0] !== e.rdata) begin
         n_fail++;
         $display("FAIL lb_hold: busy=%b done=%b rdata=%h expected 0 0 %h", busy_v[0], done_v[0], rdata_v[0], e.rdata);
      end
   endtask

   task automatic test_half_lat3();
      int   cyc;
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         start_req(2, 32'h0000_0202, (k == 0) ? 3'b101 : 3'b001, 32'hBEEF_0001);
         n_checks++;
         if (mem_rd_v[2] !== 1'b1 || mem_addr_v[2] !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL half_req[%0d]: mem_rd=%b mem_addr=%h expected 1 00000200", k, mem_rd_v[2], mem_addr_v[2]);
         end
         wait_done(2, cyc);
         n_checks++;
         if (cyc != 5) begin
            n_fail++;
            $display("FAIL half_latency[%0d]: done in cycle %0d expected 5", k, cyc);
         end
         e = exp_q[2].pop_front();
         n_checks++;
         if (rdata_v[2] !== e.rdata || err_v[2] !== e.err) begin
            n_fail++;
            $display("FAIL half_data[%0d]: rdata=%h err=%b expected %h %b", k, rdata_v[2], err_v[2], e.rdata, e.err);
         end
      end
   endtask

   task automatic test_error();
      logic [31:0] a_tab [4] = '{32'h0000_0301, 32'h0000_0301, 32'h0000_0103, 32'h0000_0102};
      logic [2:0]  f_tab [4] = '{3'b010, 3'b011, 3'b001, 3'b010};
      int          cyc;
      exp_t        e;
      for (int g = 0; g < 3; g++) begin
         for (int k = 0; k < 4; k++) begin
            start_req(g, a_tab[k], f_tab[k], 32'hCAFE_F00D);
            n_checks++;
            if (mem_rd_v[g] !== 1'b0 || mem_addr_v[g] !== {a_tab[k][31:2], 2'b00}) begin
               n_fail++;
               $display("FAIL err_req[%0d/%0d]: mem_rd=%b mem_addr=%h expected 0 %h", g, k,
                        mem_rd_v[g], mem_addr_v[g], {a_tab[k][31:2], 2'b00});
            end
            wait_done(g, cyc);
            n_checks++;
            if (cyc != 1) begin
               n_fail++;
               $display("FAIL err_latency[%0d/%0d]: done in cycle %0d expected 1", g, k, cyc);
            end
            e = exp_q[g].pop_front();
            n_checks++;
            if (rdata_v[g] !== e.rdata || err_v[g] !== e.err) begin
               n_fail++;
               $display("FAIL err_data[%0d/%0d]: rdata=%h err=%b expected %h %b", g, k, rdata_v[g], err_v[g], e.rdata, e.err);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic exp_rd, exp_done, exp_busy;
      exp_t e;
      @(posedge clk);
      #1;
      addr     = 32'h0000_0040;
      funct    = 3'b010;
      mem_word = 32'h1357_9BDF;
      exp_q[1].push_back(model_load(mem_word, 2'b00, 3'b010));
      exp_q[1].push_back(model_load(mem_word, 2'b00, 3'b010));
      start_v[1] = 1'b1;
      // start stays high through the first op and its trailing IDLE cycle.
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk);
         #1;
         if (c == 6) start_v[1] = 1'b0;
         @(negedge clk);
         exp_rd   = (c == 1) || (c == 6);
         exp_done = (c == 4) || (c == 9);
         exp_busy = (c != 5);
         n_checks++;
         if ({mem_rd_v[1], done_v[1], busy_v[1]} !== {exp_rd, exp_done, exp_busy}) begin
            n_fail++;
            $display("FAIL b2b_cycle%0d: mem_rd/done/busy got %b expected %b", c,
                     {mem_rd_v[1], done_v[1], busy_v[1]}, {exp_rd, exp_done, exp_busy});
         end
         if (done_v[1]) begin
            e = exp_q[1].pop_front();
            n_checks++;
            if (rdata_v[1] !== e.rdata || err_v[1] !== e.err) begin
               n_fail++;
               $display("FAIL b2b_data%0d: rdata=%h err=%b expected %h %b", c, rdata_v[1], err_v[1], e.rdata, e.err);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int   cyc;
      exp_t e;
      start_req(2, 32'h0000_0010, 3'b010, 32'h1234_5678);
      @(negedge clk);
      n_checks++;
      if (busy_v[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_busy: got %b expected 1", busy_v[2]);
      end
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({mem_rd_v[2], busy_v[2], done_v[2], err_v[2]} !== 4'b0000 || mem_addr_v[2] !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_async: mem_rd/busy/done/err=%b mem_addr=%h expected 0000 00000000",
                  {mem_rd_v[2], busy_v[2], done_v[2], err_v[2]}, mem_addr_v[2]);
      end
      exp_q[2].delete();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      start_req(2, 32'h0000_0001, 3'b100, 32'h0000_A500);
      n_checks++;
      if (mem_rd_v[2] !== 1'b1 || mem_addr_v[2] !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_req: mem_rd=%b mem_addr=%h expected 1 00000000", mem_rd_v[2], mem_addr_v[2]);
      end
      wait_done(2, cyc);
      n_checks++;
      if (cyc != 5) begin
         n_fail++;
         $display("FAIL mid_latency: done in cycle %0d expected 5", cyc);
      end
      e = exp_q[2].pop_front();
      n_checks++;
      if (rdata_v[2] !== e.rdata || err_v[2] !== e.err) begin
         n_fail++;
         $display("FAIL mid_data: rdata=%h err=%b expected %h %b", rdata_v[2], err_v[2], e.rdata, e.err);
      end
   endtask

   task automatic test_sweep();
      logic [31:0] a, w;
      logic [2:0]  f;
      int          cyc, r0;
      exp_t        ex, e;
      for (int g = 0; g < 3; g++) begin
         for (int off = 0; off < 4; off++) begin
            for (int fi = 0; fi < 5; fi++) begin
               a      = $urandom;
               a[1:0] = off[1:0];
               w      = $urandom;
               f      = FUNCTS[fi];
               ex     = model_load(w, a[1:0], f);
               r0     = rd_cnt[g];
               start_req(g, a, f, w);
               n_checks++;
               if (mem_rd_v[g] !== !ex.err || mem_addr_v[g] !== {a[31:2], 2'b00}) begin
                  n_fail++;
                  $display("FAIL sweep_req[%0d %0d %b]: mem_rd=%b mem_addr=%h expected %b %h", g, off, f,
                           mem_rd_v[g], mem_addr_v[g], !ex.err, {a[31:2], 2'b00});
               end
               wait_done(g, cyc);
               n_checks++;
               if (cyc != (ex.err ? 1 : LATS[g] + 2)) begin
                  n_fail++;
                  $display("FAIL sweep_latency[%0d %0d %b]: done in cycle %0d expected %0d", g, off, f,
                           cyc, ex.err ? 1 : LATS[g] + 2);
               end
               e = exp_q[g].pop_front();
               n_checks++;
               if (rdata_v[g] !== e.rdata || err_v[g] !== e.err) begin
                  n_fail++;
                  $display("FAIL sweep_data[%0d %0d %b]: rdata=%h err=%b expected %h %b", g, off, f,
                           rdata_v[g], err_v[g], e.rdata, e.err);
               end
               @(negedge clk);
               n_checks++;
               if (rd_cnt[g] - r0 != (ex.err ? 0 : 1)) begin
                  n_fail++;
                  $display("FAIL sweep_rd_count[%0d %0d %b]: got %0d expected %0d", g, off, f,
                           rd_cnt[g] - r0, ex.err ? 0 : 1);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_lb_lat1();
      test_half_lat3();
      test_error();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      for (int g = 0; g < 3; g++) begin
         n_checks++;
         if (exp_q[g].size() != 0) begin
            n_fail++;
            $display("FAIL leftover[%0d]: %0d expected results never completed", g, exp_q[g].size());
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
